// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } arb_state_e;

  // Wide enough for RETRY_MAX up to 15.
  localparam int RETRY_W = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// FIFO write-side bundle: the arbiter is the master, the FIFO is the slave.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_full;
  logic                  fifo_wr_ack;
  logic                  fifo_overflow;

  modport master (
    output fifo_wr_en,
    output fifo_data_in,
    input  fifo_full,
    input  fifo_wr_ack,
    input  fifo_overflow
  );

  modport slave (
    input  fifo_wr_en,
    input  fifo_data_in,
    output fifo_full,
    output fifo_wr_ack,
    output fifo_overflow
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr_i, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan offsets from the far end down so the nearest candidate is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s   = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
      sum_s   = (sum_s >= (IDX_W + 1)'(NUM_REQ)) ? (sum_s - (IDX_W + 1)'(NUM_REQ)) : sum_s;
      cand_s  = sum_s[IDX_W-1:0];
      valid_o = valid_o | req_i[cand_s];
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write scheduler sharing one FIFO write port between NUM_REQ producers,
// with overflow retry, drop reporting and saturating accept/drop statistics.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RETRY_MAX  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [CNT_WIDTH-1:0]          accept_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  fifo_wr_arbiter_if.master             fifo
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [RETRY_W-1:0]    retry_q;
  logic                  wr_en_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [NUM_REQ-1:0]    err_q;
  logic [CNT_WIDTH-1:0]  accept_cnt_q;
  logic [CNT_WIDTH-1:0]  accept_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_d;
  logic [NUM_REQ-1:0]    idx_onehot_s;

  logic                  pick_valid_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic [DATA_WIDTH-1:0] slice_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid_s),
    .idx_o    (pick_idx_s)
  );

  assign rr_ptr_d     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : (idx_q + IDX_W'(1));
  assign accept_cnt_d = (&accept_cnt_q) ? accept_cnt_q : (accept_cnt_q + CNT_WIDTH'(1));
  assign drop_cnt_d   = (&drop_cnt_q) ? drop_cnt_q : (drop_cnt_q + CNT_WIDTH'(1));
  assign idx_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;

  // Scheduler FSM; all outputs are registered and pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      retry_q      <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid_s && !fifo.fifo_full) begin
            idx_q   <= pick_idx_s;
            data_q  <= slice_s[pick_idx_s];
            wr_en_q <= 1'b1;
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // A missing ack is handled exactly like an overflow.
          if (fifo.fifo_wr_ack) begin
            done_q       <= idx_onehot_s;
            accept_cnt_q <= accept_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            retry_q      <= '0;
            state_q      <= IDLE;
          end else if (retry_q < RETRY_W'(RETRY_MAX)) begin
            retry_q <= retry_q + RETRY_W'(1);
            state_q <= HOLD;
          end else begin
            err_q      <= idx_onehot_s;
            drop_cnt_q <= drop_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            retry_q    <= '0;
            state_q    <= IDLE;
          end
        end
        HOLD: begin
          if (!fifo.fifo_full) begin
            wr_en_q <= 1'b1;
            state_q <= ISSUE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo.fifo_wr_en   = wr_en_q;
  assign fifo.fifo_data_in = data_q;
  assign req_done          = done_q;
  assign req_err           = err_q;
  assign accept_cnt        = accept_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule
